// File: rtl/serial_burst_router.sv
// serial_burst_router: routes one selected serial lane for a counted burst,
// pulses done at the end and keeps the newest DATA_W bits in a capture register.
module serial_burst_router #(
    parameter int N_CH   = 4,
    parameter int SEL_W  = 2,
    parameter int CNT_W  = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  nt,
    input  logic [SEL_W-1:0]  sel,
    input  logic              abort,
    input  logic [N_CH-1:0]   ser_in,
    output logic [N_CH-1:0]   ser_out,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  bit_cnt,
    output logic [DATA_W-1:0] cap_data
);

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        DONE
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  nt_q;
    logic [SEL_W-1:0]  sel_q;
    logic              lane_bit;
    logic [N_CH-1:0]   lane_mask;
    logic [CNT_W-1:0]  cnt_nxt;

    // An out-of-range select matches no lane: mask and bit stay 0.
    always_comb begin
        lane_bit  = 1'b0;
        lane_mask = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (sel_q == SEL_W'(i)) begin
                lane_bit     = ser_in[i];
                lane_mask[i] = 1'b1;
            end
        end
    end

    assign cnt_nxt = bit_cnt + CNT_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            nt_q     <= '0;
            sel_q    <= '0;
            ser_out  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            bit_cnt  <= '0;
            cap_data <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        nt_q     <= nt;
                        sel_q    <= sel;
                        bit_cnt  <= '0;
                        cap_data <= '0;
                        busy     <= 1'b1;
                        if (nt == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= XFER;
                        end
                    end
                end
                XFER: begin
                    // Abort wins over the bit sampled on this edge.
                    if (abort) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        ser_out <= '0;
                    end else begin
                        ser_out  <= {N_CH{lane_bit}} & lane_mask;
                        cap_data <= {cap_data[DATA_W-2:0], lane_bit};
                        bit_cnt  <= cnt_nxt;
                        if (cnt_nxt == nt_q) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    ser_out <= '0;
                end
                default: begin
                    state   <= IDLE;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    ser_out <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_burst_router.sv
// tb_serial_burst_router: randomized bursts checked cycle by cycle against
// a model derived from burst length, lane select and abort position.
module tb_serial_burst_router;

    localparam int N_CH   = 4;
    localparam int SEL_W  = 2;
    localparam int CNT_W  = 8;
    localparam int DATA_W = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [CNT_W-1:0]  nt;
    logic [SEL_W-1:0]  sel;
    logic              abort;
    logic [N_CH-1:0]   ser_in;
    logic [N_CH-1:0]   ser_out;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] cap_data;

    serial_burst_router #(
        .N_CH(N_CH), .SEL_W(SEL_W), .CNT_W(CNT_W), .DATA_W(DATA_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .nt(nt), .sel(sel),
        .abort(abort), .ser_in(ser_in), .ser_out(ser_out), .busy(busy),
        .done(done), .bit_cnt(bit_cnt), .cap_data(cap_data)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic              busy;
        logic              done;
        logic [N_CH-1:0]   so;
        logic [CNT_W-1:0]  cnt;
        logic [DATA_W-1:0] cap;
    } snap_t;

    int    vectors;
    int    miscompares;
    snap_t obs[64];
    logic  eb[64];
    int    m_sel;
    int    m_nt;
    int    m_abort;
    int    m_ncyc;

    function automatic snap_t snap_now();
        snap_t r;
        r.busy = busy;
        r.done = done;
        r.so   = ser_out;
        r.cnt  = bit_cnt;
        r.cap  = cap_data;
        return r;
    endfunction

    // Expected outputs observed after edge Ej (j=0 is the start edge).
    function automatic snap_t model_at(int j);
        snap_t r;
        bit    aborted;
        int    stop;
        int    nb;
        aborted = (m_abort > 0) && (m_abort <= m_nt);
        stop    = aborted ? m_abort : m_nt + 1;
        nb      = (j < m_nt) ? j : m_nt;
        if (aborted && nb > m_abort - 1) nb = m_abort - 1;
        r      = '0;
        r.busy = (j < stop);
        r.done = !aborted && (j == m_nt);
        if (j >= 1 && j < stop && j <= m_nt && m_sel < N_CH)
            r.so[m_sel] = eb[j];
        r.cnt = CNT_W'(nb);
        for (int t = 0; t < DATA_W && t < nb; t++)
            r.cap[t] = eb[nb - t];
        return r;
    endfunction

    // Called at a negedge; issues start and records outputs for ncyc edges.
    task automatic drive_burst(input int s, input int n, input int ab,
                               input int ncyc, input bit use_stream,
                               input logic [15:0] stream, input int spur_at);
        m_sel   = s;
        m_nt    = n;
        m_abort = ab;
        m_ncyc  = ncyc;
        start   = 1'b1;
        sel     = SEL_W'(s);
        nt      = CNT_W'(n);
        abort   = 1'b0;
        ser_in  = N_CH'($urandom);
        @(negedge clk);
        obs[0] = snap_now();
        for (int k = 1; k <= ncyc; k++) begin
            ser_in = N_CH'($urandom);
            if (use_stream && k <= n && s < N_CH)
                ser_in[s] = stream[n - k];
            abort = (k == ab);
            sel   = SEL_W'($urandom);
            nt    = CNT_W'($urandom);
            if (k == spur_at) begin
                start     = 1'b1;
                nt        = CNT_W'(2);
                sel       = '0;
                ser_in[0] = 1'b1;
            end else begin
                start = 1'b0;
            end
            eb[k] = (s < N_CH) ? ser_in[s] : 1'b0;
            @(negedge clk);
            obs[k] = snap_now();
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic test_reset();
        snap_t o;
        rst    = 1'b1;
        start  = 1'b0;
        abort  = 1'b0;
        nt     = '0;
        sel    = '0;
        ser_in = '0;
        repeat (2) @(negedge clk);
        o = snap_now();
        vectors++;
        if (o !== '0) begin
            miscompares++;
            $display("FAIL reset outputs got %h want 0", o);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int nbusy;
        int ndone;
        drive_burst(2, 8, 0, 9, 1'b1, 16'h00A5, 0);
        nbusy = 0;
        ndone = 0;
        for (int j = 0; j <= m_ncyc; j++) begin
            nbusy += int'(obs[j].busy);
            ndone += int'(obs[j].done);
            vectors++;
            if (obs[j] !== model_at(j)) begin
                miscompares++;
                $display("FAIL basic cyc%0d got %h want %h", j, obs[j], model_at(j));
            end
        end
        vectors++;
        if (obs[9].cap !== 8'hA5) begin
            miscompares++;
            $display("FAIL basic cap got %h want a5", obs[9].cap);
        end
        vectors++;
        if (obs[9].cnt !== 8'd8) begin
            miscompares++;
            $display("FAIL basic bit_cnt got %0d want 8", obs[9].cnt);
        end
        vectors++;
        if (nbusy != 9 || ndone != 1 || obs[8].done !== 1'b1) begin
            miscompares++;
            $display("FAIL basic timing busy=%0d done=%0d want 9/1", nbusy, ndone);
        end
    endtask

    task automatic test_zero();
        int nbusy;
        int nso;
        drive_burst($urandom_range(0, 3), 0, 0, 4, 1'b0, 16'h0, 0);
        nbusy = 0;
        nso   = 0;
        for (int j = 0; j <= m_ncyc; j++) begin
            nbusy += int'(obs[j].busy);
            nso   += (obs[j].so != '0) ? 1 : 0;
            vectors++;
            if (obs[j] !== model_at(j)) begin
                miscompares++;
                $display("FAIL zero cyc%0d got %h want %h", j, obs[j], model_at(j));
            end
        end
        vectors++;
        if (obs[0].done !== 1'b1 || nbusy != 1 || nso != 0) begin
            miscompares++;
            $display("FAIL zero timing done0=%b busy=%0d so=%0d want 1/1/0", obs[0].done, nbusy, nso);
        end
        vectors++;
        if (obs[4].cnt !== '0 || obs[4].cap !== '0) begin
            miscompares++;
            $display("FAIL zero regs got cnt=%0d cap=%h want 0/0", obs[4].cnt, obs[4].cap);
        end
    endtask

    task automatic test_capture_width();
        drive_burst($urandom_range(0, 3), 3, 0, 4, 1'b1, 16'b110, 0);
        for (int j = 0; j <= m_ncyc; j++) begin
            vectors++;
            if (obs[j] !== model_at(j)) begin
                miscompares++;
                $display("FAIL cap3 cyc%0d got %h want %h", j, obs[j], model_at(j));
            end
        end
        vectors++;
        if (obs[4].cap !== 8'h06 || obs[4].cnt !== 8'd3) begin
            miscompares++;
            $display("FAIL cap3 got cap=%h cnt=%0d want 06/3", obs[4].cap, obs[4].cnt);
        end
        drive_burst($urandom_range(0, 3), 10, 0, 11, 1'b1, 16'b11_0000_1111, 0);
        for (int j = 0; j <= m_ncyc; j++) begin
            vectors++;
            if (obs[j] !== model_at(j)) begin
                miscompares++;
                $display("FAIL cap10 cyc%0d got %h want %h", j, obs[j], model_at(j));
            end
        end
        vectors++;
        if (obs[11].cap !== 8'h0F || obs[11].cnt !== 8'd10) begin
            miscompares++;
            $display("FAIL cap10 got cap=%h cnt=%0d want 0f/10", obs[11].cap, obs[11].cnt);
        end
    endtask

    task automatic test_abort();
        int ndone;
        drive_burst(1, 8, 4, 14, 1'b1, 16'b1010_0000, 0);
        ndone = 0;
        for (int j = 0; j <= m_ncyc; j++) begin
            ndone += int'(obs[j].done);
            vectors++;
            if (obs[j] !== model_at(j)) begin
                miscompares++;
                $display("FAIL abort cyc%0d got %h want %h", j, obs[j], model_at(j));
            end
        end
        vectors++;
        if (obs[4].busy !== 1'b0 || ndone != 0) begin
            miscompares++;
            $display("FAIL abort ctl busy4=%b done=%0d want 0/0", obs[4].busy, ndone);
        end
        vectors++;
        if (obs[14].cnt !== 8'd3 || obs[14].cap !== 8'h05) begin
            miscompares++;
            $display("FAIL abort regs cnt=%0d cap=%h want 3/05", obs[14].cnt, obs[14].cap);
        end
    endtask

    task automatic test_back_to_back();
        int lane0;
        drive_burst(3, 5, 0, 6, 1'b0, 16'h0, 2);
        lane0 = 0;
        for (int j = 0; j <= m_ncyc; j++) begin
            lane0 += int'(obs[j].so[0]);
            vectors++;
            if (obs[j] !== model_at(j)) begin
                miscompares++;
                $display("FAIL busyprot cyc%0d got %h want %h", j, obs[j], model_at(j));
            end
        end
        vectors++;
        if (lane0 != 0 || obs[5].cnt !== 8'd5) begin
            miscompares++;
            $display("FAIL busyprot lane0=%0d cnt=%0d want 0/5", lane0, obs[5].cnt);
        end
        drive_burst(0, 2, 0, 3, 1'b1, 16'b10, 0);
        for (int j = 0; j <= m_ncyc; j++) begin
            vectors++;
            if (obs[j] !== model_at(j)) begin
                miscompares++;
                $display("FAIL b2b cyc%0d got %h want %h", j, obs[j], model_at(j));
            end
        end
        vectors++;
        if (obs[2].done !== 1'b1 || obs[3].cap !== 8'h02) begin
            miscompares++;
            $display("FAIL b2b done2=%b cap=%h want 1/02", obs[2].done, obs[3].cap);
        end
    endtask

    task automatic test_async_reset();
        snap_t o;
        int    bad;
        start = 1'b1;
        sel   = SEL_W'(2);
        nt    = CNT_W'(8);
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            ser_in    = N_CH'($urandom);
            ser_in[2] = 1'b1;
            @(negedge clk);
        end
        vectors++;
        if (busy !== 1'b1 || ser_out !== 4'b0100) begin
            miscompares++;
            $display("FAIL arst pre busy=%b so=%b want 1/0100", busy, ser_out);
        end
        #2 rst = 1'b1;
        #1 o = snap_now();
        vectors++;
        if (o !== '0) begin
            miscompares++;
            $display("FAIL arst immediate got %h want 0", o);
        end
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            ser_in = N_CH'($urandom);
            @(negedge clk);
            bad += int'(done) + int'(busy);
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL arst after got %0d busy/done cycles want 0", bad);
        end
    endtask

    task automatic test_random();
        int s;
        int n;
        int ab;
        for (int b = 0; b < 25; b++) begin
            s  = $urandom_range(0, N_CH - 1);
            n  = $urandom_range(0, 20);
            ab = ($urandom_range(0, 2) == 0) ? $urandom_range(1, n + 2) : 0;
            drive_burst(s, n, ab, n + 3, 1'b0, 16'h0, 0);
            for (int j = 0; j <= m_ncyc; j++) begin
                vectors++;
                if (obs[j] !== model_at(j)) begin
                    miscompares++;
                    $display("FAIL rand b%0d nt=%0d sel=%0d ab=%0d cyc%0d got %h want %h",
                             b, n, s, ab, j, obs[j], model_at(j));
                end
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_basic();
        test_zero();
        test_capture_width();
        test_abort();
        test_back_to_back();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
